// File: rtl/player_link_rx.sv
// player_link_rx: receives 8N1 status frames from the remote board and
// decodes its player-ready flags and current player.
//   clk60MHz         system clock
//   rst              synchronous reset, active-high
//   rx               asynchronous serial line, idles high
//   in_player1_ready remote board holds player 1
//   in_player2_ready remote board holds player 2
//   remote_player    remote board's current_player bit
//   frame_valid      1-cycle pulse on an accepted frame
//   frame_error      1-cycle pulse on a rejected frame
//   link_lost        no valid frame within TIMEOUT_CYCLES
module player_link_rx #(
    parameter int unsigned CLKS_PER_BIT   = 521,
    parameter int unsigned TIMEOUT_CYCLES = 6_000_000
) (
    input  logic clk60MHz,
    input  logic rst,
    input  logic rx,
    output logic in_player1_ready,
    output logic in_player2_ready,
    output logic remote_player,
    output logic frame_valid,
    output logic frame_error,
    output logic link_lost
);

    localparam int unsigned HALF_BIT    = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned TO_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  SYNC_NIBBLE = 4'hA;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic              rx_meta, rx_s;
    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_q;
    logic              stop_bit_q;
    logic              check_q;
    logic [TO_W-1:0]   to_cnt;

    logic cnt_clr_c, bit_clr_c, data_sample_c, stop_sample_c;
    logic half_tick_c, bit_tick_c, frame_ok_c;

    // State register
    always_ff @(posedge clk60MHz) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and bit-timing strobes
    always_comb begin
        state_d       = state_q;
        cnt_clr_c     = 1'b0;
        bit_clr_c     = 1'b0;
        data_sample_c = 1'b0;
        stop_sample_c = 1'b0;
        half_tick_c   = (clk_cnt == CNT_W'(HALF_BIT - 1));
        bit_tick_c    = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                cnt_clr_c = 1'b1;
                if (!rx_s) begin
                    state_d   = START;
                    bit_clr_c = 1'b1;
                end
            end
            START: begin
                // Mid start bit: a high line here was only a glitch
                if (half_tick_c) begin
                    cnt_clr_c = 1'b1;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    cnt_clr_c     = 1'b1;
                    data_sample_c = 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    cnt_clr_c     = 1'b1;
                    stop_sample_c = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizer, bit counters and shift register
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_q    <= '0;
            stop_bit_q <= 1'b0;
            check_q    <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            clk_cnt <= cnt_clr_c ? '0 : clk_cnt + CNT_W'(1);
            if (bit_clr_c)
                bit_idx <= '0;
            else if (data_sample_c && bit_idx != 3'd7)
                bit_idx <= bit_idx + 3'd1;
            if (data_sample_c) shift_q[bit_idx] <= rx_s;
            if (stop_sample_c) stop_bit_q <= rx_s;
            check_q <= stop_sample_c;
        end
    end

    // Frame accepted only with good stop bit, sync nibble, reserved bit and
    // at most one player claimed
    assign frame_ok_c = stop_bit_q && (shift_q[7:4] == SYNC_NIBBLE) &&
                        !shift_q[3] && (shift_q[1:0] != 2'b11);

    // Decoded outputs and link watchdog; an accepted frame beats the timeout
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            in_player1_ready <= 1'b0;
            in_player2_ready <= 1'b0;
            remote_player    <= 1'b0;
            frame_valid      <= 1'b0;
            frame_error      <= 1'b0;
            link_lost        <= 1'b1;
            to_cnt           <= '0;
        end else begin
            frame_valid <= check_q && frame_ok_c;
            frame_error <= check_q && !frame_ok_c;
            if (check_q && frame_ok_c) begin
                in_player1_ready <= shift_q[0];
                in_player2_ready <= shift_q[1];
                remote_player    <= shift_q[2];
                link_lost        <= 1'b0;
                to_cnt           <= '0;
            end else begin
                if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    link_lost        <= 1'b1;
                    in_player1_ready <= 1'b0;
                    in_player2_ready <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_link_rx.sv
// Directed bench for player_link_rx with CLKS_PER_BIT=8, TIMEOUT_CYCLES=2000.
module tb_player_link_rx;

    localparam int unsigned CPB = 8;
    localparam int unsigned TO  = 2000;

    logic clk60MHz = 1'b0;
    logic rst      = 1'b1;
    logic rx       = 1'b1;
    logic in_player1_ready, in_player2_ready, remote_player;
    logic frame_valid, frame_error, link_lost;

    player_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TO)) dut (
        .clk60MHz         (clk60MHz),
        .rst              (rst),
        .rx               (rx),
        .in_player1_ready (in_player1_ready),
        .in_player2_ready (in_player2_ready),
        .remote_player    (remote_player),
        .frame_valid      (frame_valid),
        .frame_error      (frame_error),
        .link_lost        (link_lost)
    );

    always #5 clk60MHz = ~clk60MHz;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic       v, e, p1, p2, rp, ll;
    } vec_t;

    typedef struct {
        logic v, e, p1, p2, rp, ll;
        int   cyc;
    } snap_t;

    snap_t pulses[$];
    int    cyc    = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;

    // Record every pulse with the outputs seen in that cycle
    always @(negedge clk60MHz) begin
        cyc = cyc + 1;
        if (frame_valid || frame_error)
            pulses.push_back('{frame_valid, frame_error, in_player1_ready,
                               in_player2_ready, remote_player, link_lost, cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk60MHz);
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic check_outs(input string name, input logic p1, input logic p2,
                              input logic rp, input logic ll);
        check({name, ".p1"}, in_player1_ready, p1);
        check({name, ".p2"}, in_player2_ready, p2);
        check({name, ".rp"}, remote_player, rp);
        check({name, ".ll"}, link_lost, ll);
    endtask

    task automatic check_snap(input string name, input int idx, input logic v, input logic e,
                              input logic p1, input logic p2, input logic rp, input logic ll);
        check({name, ".present"}, 32'(idx < pulses.size()), 32'd1);
        if (idx < pulses.size()) begin
            check({name, ".valid"}, pulses[idx].v, v);
            check({name, ".error"}, pulses[idx].e, e);
            check({name, ".excl"},  pulses[idx].v & pulses[idx].e, 1'b0);
            check({name, ".p1"},    pulses[idx].p1, p1);
            check({name, ".p2"},    pulses[idx].p2, p2);
            check({name, ".rp"},    pulses[idx].rp, rp);
            check({name, ".ll"},    pulses[idx].ll, ll);
        end
    endtask

    vec_t vecs[5];

    initial begin
        int base, n0, target;
        vecs[0] = '{8'hA1, 1'b1, 6,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA6, 1'b1, 0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hA3, 1'b1, 6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hB1, 1'b1, 6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'hA1, 1'b0, 12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Reset and idle line
        tick(5);
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset.fv", frame_valid, 1'b0);
        check("reset.fe", frame_error, 1'b0);
        rst = 1'b0;
        tick(100);
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b1);
        check("idle.pulses", pulses.size(), 0);

        // Frame table: valid, back-to-back pair, bad sync, bad stop bit
        base = pulses.size();
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            tick(vecs[i].gap);
        end
        check("table.count", pulses.size(), base + 5);
        for (int i = 0; i < 5; i++)
            check_snap($sformatf("vec%0d", i), base + i, vecs[i].v, vecs[i].e,
                       vecs[i].p1, vecs[i].p2, vecs[i].rp, vecs[i].ll);

        // False starts of 2 and 3 cycles
        n0 = pulses.size();
        rx = 1'b0; tick(2);
        rx = 1'b1; tick(20);
        rx = 1'b0; tick(3);
        rx = 1'b1; tick(20);
        check("glitch.pulses", pulses.size(), n0);
        check_outs("glitch", 1'b0, 1'b1, 1'b1, 1'b0);

        // Valid frame then silence until the watchdog fires
        n0 = pulses.size();
        send_frame(8'hA1, 1'b1);
        tick(10);
        check_snap("a1", n0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        if (n0 < pulses.size()) begin
            target = pulses[n0].cyc + int'(TO) - 1;
            do begin @(negedge clk60MHz); #1; end while (cyc < target);
            check_outs("to_minus1", 1'b1, 1'b0, 1'b0, 1'b0);
            @(negedge clk60MHz); #1;
            check_outs("to_limit", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Re-establish link, then reset during DATA bits
        n0 = pulses.size();
        send_frame(8'hA6, 1'b1);
        tick(10);
        check_snap("a6", n0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n0 = pulses.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst = 1'b1;
        rx  = 1'b1;
        tick(3);
        check_outs("midrst", 1'b0, 1'b0, 1'b0, 1'b1);
        check("midrst.fv", frame_valid, 1'b0);
        check("midrst.fe", frame_error, 1'b0);
        rst = 1'b0;
        tick(200);
        check("midrst.pulses", pulses.size(), n0);
        check_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_link_rx.md
Name: player_link_rx

Overview:
- Receives status frames sent over a single serial wire by the opposite board in the two-board game.
- Decodes the remote board's player1/player2 ready flags and its current player.
- Drives the in_player1_ready / in_player2_ready inputs of the local player-selection logic.
- Validates every frame and clears the remote flags if the link goes silent.

Parameters:
- CLKS_PER_BIT, 521, clk60MHz cycles per serial bit (60 MHz / 115200 baud); minimum 4.
- TIMEOUT_CYCLES, 6_000_000, cycles without a valid frame before link_lost asserts (100 ms).

Ports:
- clk60MHz  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx  input  1  asynchronous serial line from remote board; idles high
- in_player1_ready  output  1  remote board has chosen player 1
- in_player2_ready  output  1  remote board has chosen player 2
- remote_player  output  1  remote board's current_player bit
- frame_valid  output  1  one-cycle pulse when a valid frame is accepted
- frame_error  output  1  one-cycle pulse when a frame is rejected
- link_lost  output  1  no valid frame received within TIMEOUT_CYCLES

Behaviour:
- Clocking and reset: clock clk60MHz; reset rst, synchronous, active-high.
- Reset values:
  - in_player1_ready=0, in_player2_ready=0, remote_player=0
  - frame_valid=0, frame_error=0, link_lost=1
  - state=IDLE, all counters 0, synchronizer flops=1
- rx synchronization: rx passes through a 2-flop synchronizer before any use. All bit sampling uses the synchronized value rx_s.
- Frame format: 8N1, LSB first.
  - Data byte bits [7:4] = sync nibble 4'hA; bit [3] = 0 (reserved).
  - Bit [2] = current_player; bit [1] = player2_ready; bit [0] = player1_ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_s == 0, go to START and clear the bit counter.
  - START: wait CLKS_PER_BIT/2 cycles (integer division), then sample rx_s.
    - rx_s == 1: false start; return to IDLE with no error pulse.
    - rx_s == 0: go to DATA and reset the bit-time counter.
  - DATA: sample rx_s every CLKS_PER_BIT cycles into shift-register bit index 0..7. After the 8th sample, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s, then return to IDLE on the next cycle. Back-to-back frames are supported, with no idle bit required beyond the stop bit.
- Validation at the stop-bit sample. A frame is valid only if all of the following hold:
  - stop bit == 1
  - byte[7:4] == 4'hA
  - byte[3] == 0
  - byte[1:0] != 2'b11 (remote cannot hold both players)
- Valid frame, on the cycle after the stop sample:
  - in_player1_ready <= byte[0], in_player2_ready <= byte[1], remote_player <= byte[2]
  - frame_valid pulses 1 cycle; link_lost <= 0; timeout counter <= 0
- Invalid frame: frame_error pulses 1 cycle; ready outputs and remote_player hold their values; timeout counter keeps running.
- Timeout:
  - Counter increments every cycle not accepting a valid frame; it saturates at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES: link_lost <= 1, in_player1_ready <= 0, in_player2_ready <= 0; remote_player holds.
  - A valid frame on the same cycle as the timeout reaches its limit wins: outputs update and link_lost=0.
- Latency: outputs change exactly 1 cycle after the stop-bit sample, which is about 9.5 bit times after the start-bit falling edge.
- Reset mid-frame: the frame is abandoned, FSM returns to IDLE, and outputs take their reset values. A partially received frame never produces frame_valid or frame_error.
- frame_valid and frame_error are never high in the same cycle.

Test Plan (CLKS_PER_BIT=8, TIMEOUT_CYCLES=2000):
1. Reset, rx idle high for 100 cycles -> all ready outputs 0, link_lost=1, no pulses.
2. Send byte 8'hA1 -> 1 cycle after stop sample: frame_valid=1, in_player1_ready=1, in_player2_ready=0, remote_player=0, link_lost=0.
3. Send 8'hA6, then 8'hA3 back-to-back ->
   - first frame: in_player2_ready=1, remote_player=1, frame_valid pulse
   - second frame: frame_error pulse, outputs unchanged
4. Send 8'hB1, then 8'hA1 with stop bit forced 0 -> two frame_error pulses, outputs held.
5. Two false starts: 2-cycle low glitch on rx, then a 3-cycle low glitch (still shorter than the 4-cycle half-bit) -> FSM returns to IDLE each time, no pulses, outputs unchanged.
6. After a valid 8'hA1, hold rx high for 2000 cycles -> link_lost=1 and in_player1_ready=0 exactly at the limit. Assert rst during the DATA bits of a later frame -> reset values, no pulse.
